// File: rtl/vend_ctrl_multi_if.sv
// Handshake bundle between the coin/keypad front end and the vending controller.
// The master side is the front end; the slave side is the controller.
interface vend_ctrl_multi_if #(
   parameter int SEL_W    = 2,
   parameter int CREDIT_W = 6
);
   logic [1:0]          in;
   logic [SEL_W-1:0]    sel;
   logic                vend_req;
   logic                cancel;
   logic                out;
   logic [SEL_W-1:0]    item;
   logic [1:0]          change;
   logic [CREDIT_W-1:0] credit;
   logic                coin_reject;
   logic                deny;
   logic                busy;

   modport master (output in, sel, vend_req, cancel,
                   input  out, item, change, credit, coin_reject, deny, busy);
   modport slave  (input  in, sel, vend_req, cancel,
                   output out, item, change, credit, coin_reject, deny, busy);
endinterface

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: bounded credit, per-product prices,
// greedy one-coin-per-cycle change, cancel refund and inactivity timeout.
module vend_ctrl_multi #(
   parameter int                          N_PROD      = 4,
   parameter int                          SEL_W       = 2,
   parameter int                          CREDIT_W    = 6,
   parameter int                          MAX_CREDIT  = 40,
   parameter int                          COIN_HI     = 5,
   parameter logic [N_PROD*CREDIT_W-1:0]  PRICES      = {6'd12, 6'd7, 6'd4, 6'd3},
   parameter int                          TIMEOUT_CYC = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   vend_ctrl_multi_if.slave     bus
);
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

   state_t              state, state_nxt;
   logic [CREDIT_W-1:0] credit_q, credit_nxt;
   logic [SEL_W-1:0]    item_q, item_nxt;
   logic [CNT_W-1:0]    idle_cnt, idle_cnt_nxt;
   logic                reject_q, reject_nxt;
   logic                deny_q, deny_nxt;

   logic                coin;
   logic [CREDIT_W:0]   coin_val;
   logic [CREDIT_W:0]   credit_sum;
   logic [CREDIT_W-1:0] price_sel;
   logic                sel_valid;
   logic [1:0]          change_code;
   logic [CREDIT_W-1:0] change_val;

   // Price lookup; selections beyond the product range are flagged invalid.
   always_comb begin
      price_sel = '0;
      sel_valid = 1'b0;
      for (int i = 0; i < N_PROD; i++) begin
         if (bus.sel == SEL_W'(i)) begin
            price_sel = PRICES[i*CREDIT_W +: CREDIT_W];
            sel_valid = 1'b1;
         end
      end
   end

   always_comb begin
      coin_val = '0;
      unique case (bus.in)
         2'b01:   coin_val = (CREDIT_W+1)'(1);
         2'b10:   coin_val = (CREDIT_W+1)'(2);
         2'b11:   coin_val = (CREDIT_W+1)'(COIN_HI);
         default: coin_val = '0;
      endcase
   end

   assign coin       = (bus.in != 2'b00);
   assign credit_sum = {1'b0, credit_q} + coin_val;

   // Greedy change coin chosen from the credit still owed.
   always_comb begin
      change_code = 2'b01;
      change_val  = CREDIT_W'(1);
      if (credit_q >= CREDIT_W'(COIN_HI)) begin
         change_code = 2'b11;
         change_val  = CREDIT_W'(COIN_HI);
      end else if (credit_q >= CREDIT_W'(2)) begin
         change_code = 2'b10;
         change_val  = CREDIT_W'(2);
      end
   end

   always_comb begin
      state_nxt    = state;
      credit_nxt   = credit_q;
      item_nxt     = item_q;
      idle_cnt_nxt = idle_cnt;
      reject_nxt   = 1'b0;
      deny_nxt     = 1'b0;
      unique case (state)
         IDLE: begin
            if (coin) begin
               credit_nxt   = coin_val[CREDIT_W-1:0];
               idle_cnt_nxt = '0;
               state_nxt    = CREDIT;
            end
            if (bus.vend_req) deny_nxt = 1'b1;
         end
         CREDIT: begin
            if (bus.cancel) begin
               reject_nxt   = coin;
               idle_cnt_nxt = '0;
               state_nxt    = CHANGE;
            end else if (bus.vend_req) begin
               reject_nxt   = coin;
               idle_cnt_nxt = '0;
               if (!sel_valid || price_sel > credit_q) begin
                  deny_nxt = 1'b1;
               end else begin
                  item_nxt   = bus.sel;
                  credit_nxt = credit_q - price_sel;
                  state_nxt  = VEND;
               end
            end else if (idle_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               // This cycle completes the inactive run; the timeout outranks any coin.
               reject_nxt   = coin;
               idle_cnt_nxt = '0;
               state_nxt    = CHANGE;
            end else if (coin && credit_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
               credit_nxt   = credit_sum[CREDIT_W-1:0];
               idle_cnt_nxt = '0;
            end else begin
               reject_nxt   = coin;
               idle_cnt_nxt = idle_cnt + CNT_W'(1);
            end
         end
         VEND: begin
            reject_nxt = coin;
            state_nxt  = (credit_q != '0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            reject_nxt = coin;
            credit_nxt = credit_q - change_val;
            if (credit_q == change_val) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         credit_q <= '0;
         item_q   <= '0;
         idle_cnt <= '0;
         reject_q <= 1'b0;
         deny_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         credit_q <= credit_nxt;
         item_q   <= item_nxt;
         idle_cnt <= idle_cnt_nxt;
         reject_q <= reject_nxt;
         deny_q   <= deny_nxt;
      end
   end

   assign bus.out         = (state == VEND);
   assign bus.item        = item_q;
   assign bus.change      = (state == CHANGE) ? change_code : 2'b00;
   assign bus.credit      = credit_q;
   assign bus.coin_reject = reject_q;
   assign bus.deny        = deny_q;
   assign bus.busy        = (state == VEND) || (state == CHANGE);
endmodule
